mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit sitting directly upstream of the byte-lane data RAM.
//  - Decodes load/store ops, generates RAM ce/we/addr/sel/data, and aligns read data for writeback.
//  - Byte order is big-endian: addr[1:0]=0 selects data[31:24].
//  - RAM read data is registered, so it arrives 1 cycle after ce.
//  - Stalls the pipeline with req_ready while a load is in flight.
// PARAMETERS
//  ADDR_W  32  byte address width (mem_addr passes through unmodified)
//  DATA_W  32  fixed; any other value is illegal
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   request present this cycle
//  req_ready  out  1   1 = request accepted this cycle (state==IDLE)
//  req_op     in   4   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW,11 SWL,12 SWR,13 LL,14 SC
//  req_addr   in   32  effective byte address
//  req_rt     in   32  rt value (store data / LWL-LWR merge source)
//  req_wd     in   5   destination register
//  llbit_clr  in   1   clear LLbit (eret/exception)
//  resp_valid out  1   1-cycle pulse, response complete
//  resp_wen   out  1   write resp_wdata to resp_wd
//  resp_wd    out  5   destination register
//  resp_wdata out  32  aligned load result / SC status
//  resp_misal out  1   address-error flag
//  mem_ce     out  1   RAM chip enable
//  mem_we     out  1   RAM write enable
//  mem_addr   out  32  RAM byte address
//  mem_sel    out  4   byte lanes; sel[3]=data[31:24]
//  mem_wdata  out  32  RAM write data
//  mem_rdata  in   32  RAM read data, valid the cycle after a read ce
// BEHAVIOUR
//  - Reset: state=IDLE; LLbit=0; resp_*=0; mem_* = 0.
//  - FSM: IDLE -> RD_WAIT (load accepted) -> RESP -> IDLE.
//  - FSM: IDLE -> RESP (store, SC, or misaligned op) -> IDLE.
//  - req_ready = (state==IDLE).
//  - mem_* outputs are combinational from req_* in IDLE while req_valid=1; they are 0 in every other state.
//  - Load accepted in cycle N: ce=1, we=0, sel=4'b1111.
//    - N+1 (RD_WAIT): align mem_rdata and register it.
//    - N+2 (RESP): resp_valid=1, resp_wen=1.
//  - Store accepted in cycle N: ce=1, we=1 in N; resp_valid=1, resp_wen=0 in N+1.
//  - Alignment rules:
//    - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW/LL/SC with addr[1:0]!=0.
//    - Misaligned ops drive ce=0 (no access) and give resp_valid at N+1 with resp_misal=1, resp_wen=0.
//  - LB/LBU: selected byte, sign- or zero-extended. LH/LHU: half (addr[1]=0 -> [31:16]).
//  - SB: sel=4'b1000>>a, data={4{rt[7:0]}}. SH: sel=a[1]?0011:1100, data={2{rt[15:0]}}.
//  - SWL, by a = 0/1/2/3:
//    - sel = 1111 / 0111 / 0011 / 0001
//    - data = rt >> (8*a)
//  - SWR, by a = 0/1/2/3:
//    - sel = 1000 / 1100 / 1110 / 1111
//    - data = rt << (8*(3-a))
//  - LWL (m=mem_rdata):
//    - a=0: m
//    - a=1: {m[23:0],rt[7:0]}
//    - a=2: {m[15:0],rt[15:0]}
//    - a=3: {m[7:0],rt[23:0]}
//  - LWR:
//    - a=0: {rt[31:8],m[31:24]}
//    - a=1: {rt[31:16],m[31:16]}
//    - a=2: {rt[31:24],m[31:8]}
//    - a=3: m
//  - req_rt, req_wd and req_addr[1:0] are latched at accept; req_* may change afterwards.
//  - rst in RD_WAIT or RESP: return to IDLE in the next cycle; no resp_valid; no write is issued.
//  - llbit_clr has priority over an LL set in the same cycle.
//  - req_op values 7 and 15: treated as NOP. Accepted, ce=0, resp_valid at N+1, resp_wen=0.
// CONFIGURATION
//  LSU_LLSC_EN defined:
//    - LL behaves as LW and sets LLbit at accept.
//    - SC with LLbit=1: write like SW, resp_wdata=1, clear LLbit.
//    - SC with LLbit=0: ce=0, resp_wdata=0.
//    - SC always responds with resp_wen=1.
//  LSU_LLSC_EN undefined:
//    - No LLbit register.
//    - LL behaves exactly as LW; SC behaves exactly as SW (resp_wen=0).
//    - llbit_clr is ignored.
// TESTING
//  1 LB addr=0x11, RAM word 0x12F45678:
//    - N: ce=1, we=0, addr=0x11.
//    - N+2: resp_valid=1, resp_wdata=0xFFFFFFF4; LBU gives 0x000000F4.
//  2 SH addr=0x22, rt=0x0000ABCD:
//    - N: sel=0011, mem_wdata=0xABCDABCD, we=1.
//    - N+1: resp_valid=1, resp_wen=0.
//  3 LWL addr=0x41, word 0x11223344, rt=0xAABBCCDD -> resp_wdata=0x223344DD.
//    LWR addr=0x42 with the same word and rt -> resp_wdata=0xAA112233.
//  4 LW addr=0x06 -> ce=0 in N; resp_misal=1 at N+1; req_ready=1 at N+1.
//  5 Load accepted, rst=1 in N+1 -> state IDLE at N+2, no resp_valid; then a fresh LW completes normally.
//  6 LSU_LLSC_EN:
//    - LL 0x80, then SC 0x80 -> write issued, resp_wdata=1.
//    - LL, llbit_clr, SC -> ce=0, resp_wdata=0.
//    - Back-to-back req_valid: req_ready=0 in RD_WAIT and RESP.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response/RAM bundle between the pipeline MEM stage, mem_lsu and the data RAM
interface mem_lsu_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_rt;
   logic [4:0]        req_wd;
   logic              llbit_clr;
   logic              resp_valid;
   logic              resp_wen;
   logic [4:0]        resp_wd;
   logic [31:0]       resp_wdata;
   logic              resp_misal;
   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_sel;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   modport master (
      output req_valid, req_op, req_addr, req_rt, req_wd, llbit_clr, mem_rdata,
      input  req_ready, resp_valid, resp_wen, resp_wd, resp_wdata, resp_misal,
             mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
   );
   modport slave (
      input  req_valid, req_op, req_addr, req_rt, req_wd, llbit_clr, mem_rdata,
      output req_ready, resp_valid, resp_wen, resp_wd, resp_wdata, resp_misal,
             mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
   );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: big-endian MEM-stage load/store unit in front of a registered byte-lane RAM; LSU_LLSC_EN enables LL/SC tracking
module mem_lsu (
   input logic     clk,
   input logic     rst,
   mem_lsu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
   localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4,
                          OP_LWL = 4'd5, OP_LWR = 4'd6, OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10,
                          OP_SWL = 4'd11, OP_SWR = 4'd12, OP_LL = 4'd13, OP_SC = 4'd14;
   state_t      state, state_nx;
   logic [3:0]  op, op_q;
   logic [1:0]  a, a_q;
   logic [31:0] rt, rt_q, data_q, ld_data, wdata;
   logic [4:0]  wd_q;
   logic [3:0]  sel;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        accept, is_load, is_store, misal, sc_ok, sc_wen, ce, we, misal_q, wen_q, resp;
   assign op      = bus.req_op;
   assign a       = bus.req_addr[1:0];
   assign rt      = bus.req_rt;
   assign accept  = state == IDLE && bus.req_valid;
   assign is_load = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL};
   assign is_store = op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   assign misal   = ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
                    ((op inside {OP_LW, OP_SW, OP_LL, OP_SC}) && a != 2'd0);
`ifdef LSU_LLSC_EN
   logic llbit;
   assign sc_ok  = llbit;
   assign sc_wen = op == OP_SC;
   // LLbit: set by an accepted LL, consumed by an accepted SC; an external clear always wins
   always_ff @(posedge clk) begin
      if (rst) llbit <= 1'b0;
      else if (bus.llbit_clr) llbit <= 1'b0;
      else if (accept && !misal && op == OP_LL) llbit <= 1'b1;
      else if (accept && !misal && op == OP_SC) llbit <= 1'b0;
   end
`else
   logic unused_llbit_clr;
   assign sc_ok            = 1'b1;
   assign sc_wen           = 1'b0;
   assign unused_llbit_clr = bus.llbit_clr;
`endif
   // SC without a reservation, misaligned ops and NOPs never touch the RAM
   assign ce = accept && !misal && (is_load || is_store || (op == OP_SC && sc_ok));
   assign we = ce && !is_load;
   // store lane enables and replicated/shifted write data (big-endian: lane 3 is addr offset 0)
   always_comb begin
      sel   = 4'b1111;
      wdata = rt;
      case (op)
         OP_SB: begin
            sel   = 4'b1000 >> a;
            wdata = {4{rt[7:0]}};
         end
         OP_SH: begin
            sel   = a[1] ? 4'b0011 : 4'b1100;
            wdata = {2{rt[15:0]}};
         end
         OP_SWL: begin
            sel   = 4'b1111 >> a;
            wdata = rt >> {a, 3'b000};
         end
         OP_SWR: begin
            sel   = 4'b1111 << ~a;
            wdata = rt << {~a, 3'b000};
         end
         default: ;
      endcase
   end
   assign bus.mem_ce    = ce;
   assign bus.mem_we    = we;
   assign bus.mem_addr  = ce ? bus.req_addr : '0;
   assign bus.mem_sel   = ce ? sel : 4'b0000;
   assign bus.mem_wdata = we ? wdata : 32'd0;
   assign ld_byte = 8'(bus.mem_rdata >> {~a_q, 3'b000});
   assign ld_half = a_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
   // align the registered RAM word for writeback; LWL/LWR merge with the latched rt
   always_comb begin
      ld_data = bus.mem_rdata;
      case (op_q)
         OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_data = {24'd0, ld_byte};
         OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU: ld_data = {16'd0, ld_half};
         OP_LWL: ld_data = (bus.mem_rdata << {a_q, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF << {a_q, 3'b000}));
         OP_LWR: ld_data = (bus.mem_rdata >> {~a_q, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF >> {~a_q, 3'b000}));
         default: ;
      endcase
   end
   // next state: only aligned loads wait for RAM data, everything else answers next cycle
   always_comb begin
      state_nx = state == IDLE    ? (accept ? ((is_load && !misal) ? RD_WAIT : RESP) : IDLE) :
                 state == RD_WAIT ? RESP : IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   // capture request context at accept, then the aligned load word while waiting on the RAM
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= 4'd0;
         a_q     <= 2'd0;
         rt_q    <= 32'd0;
         wd_q    <= 5'd0;
         misal_q <= 1'b0;
         wen_q   <= 1'b0;
         data_q  <= 32'd0;
      end else if (accept) begin
         op_q    <= op;
         a_q     <= a;
         rt_q    <= rt;
         wd_q    <= bus.req_wd;
         misal_q <= misal;
         wen_q   <= !misal && (is_load || sc_wen);
         data_q  <= {31'd0, sc_wen && sc_ok && !misal};
      end else if (state == RD_WAIT) begin
         data_q  <= ld_data;
      end
   end
   assign resp           = state == RESP;
   assign bus.req_ready  = state == IDLE;
   assign bus.resp_valid = resp;
   assign bus.resp_wen   = resp && wen_q;
   assign bus.resp_wd    = resp ? wd_q : 5'd0;
   assign bus.resp_wdata = (resp && wen_q) ? data_q : 32'd0;
   assign bus.resp_misal = resp && misal_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed-vector bench for mem_lsu with a registered byte-lane RAM model
module tb_mem_lsu;
   localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4, LWL = 4'd5, LWR = 4'd6,
                          SB = 4'd8, SH = 4'd9, SW = 4'd10, SWL = 4'd11, SWR = 4'd12, LL = 4'd13, SC = 4'd14;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_at_accept = 1'b0;
   logic [31:0] ram [64];
   int          n_vec = 0;
   int          n_bad = 0;
   mem_lsu_if bus ();
   mem_lsu dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // RAM model: registered read, byte-lane write, fixed preload while in reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
         ram[4]        <= 32'h12F4_5678;
         ram[16]       <= 32'h1122_3344;
         ram[32]       <= 32'h0BAD_F00D;
         bus.mem_rdata <= 32'd0;
      end else begin
         if (bus.mem_ce && bus.mem_we)
            for (int b = 0; b < 4; b++)
               if (bus.mem_sel[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         if (bus.mem_ce && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] wd);
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_rt    = rt;
      bus.req_wd    = wd;
   endtask
   task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [4:0] wd, input logic [31:0] exp);
      @(negedge clk);
      drive(1'b1, op, addr, rt, wd);
      bus.llbit_clr = clr_at_accept;
      #1;
      chk("ld_ready_n", 32'(bus.req_ready), 32'd1);
      chk("ld_ce_n", 32'(bus.mem_ce), 32'd1);
      chk("ld_we_n", 32'(bus.mem_we), 32'd0);
      chk("ld_sel_n", 32'(bus.mem_sel), 32'hF);
      chk("ld_addr_n", bus.mem_addr, addr);
      @(negedge clk);
      drive(1'b0, ~op, ~addr, ~rt, ~wd);
      bus.llbit_clr = 1'b0;
      #1;
      chk("ld_ready_n1", 32'(bus.req_ready), 32'd0);
      chk("ld_rvalid_n1", 32'(bus.resp_valid), 32'd0);
      chk("ld_ce_n1", 32'(bus.mem_ce), 32'd0);
      @(negedge clk);
      #1;
      chk("ld_rvalid_n2", 32'(bus.resp_valid), 32'd1);
      chk("ld_wen_n2", 32'(bus.resp_wen), 32'd1);
      chk("ld_wd_n2", 32'(bus.resp_wd), 32'(wd));
      chk("ld_misal_n2", 32'(bus.resp_misal), 32'd0);
      chk("ld_wdata_n2", bus.resp_wdata, exp);
   endtask
   task automatic do_short(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic ce, input logic [3:0] sel, input logic [31:0] wdata,
                           input logic wen, input logic [31:0] rdata, input logic misal);
      @(negedge clk);
      drive(1'b1, op, addr, rt, 5'd3);
      #1;
      chk("st_ready_n", 32'(bus.req_ready), 32'd1);
      chk("st_ce_n", 32'(bus.mem_ce), 32'(ce));
      chk("st_we_n", 32'(bus.mem_we), 32'(ce));
      if (ce) begin
         chk("st_sel_n", 32'(bus.mem_sel), 32'(sel));
         chk("st_wdata_n", bus.mem_wdata, wdata);
         chk("st_addr_n", bus.mem_addr, addr);
      end
      @(negedge clk);
      drive(1'b0, ~op, ~addr, ~rt, 5'd0);
      #1;
      chk("st_rvalid_n1", 32'(bus.resp_valid), 32'd1);
      chk("st_wen_n1", 32'(bus.resp_wen), 32'(wen));
      chk("st_misal_n1", 32'(bus.resp_misal), 32'(misal));
      chk("st_ce_n1", 32'(bus.mem_ce), 32'd0);
      if (wen) chk("st_wdata_n1", bus.resp_wdata, rdata);
      @(negedge clk);
      #1;
      chk("st_rvalid_n2", 32'(bus.resp_valid), 32'd0);
      chk("st_ready_n2", 32'(bus.req_ready), 32'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      bus.llbit_clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rst_wen", 32'(bus.resp_wen), 32'd0);
      chk("rst_wdata", bus.resp_wdata, 32'd0);
      chk("rst_ce", 32'(bus.mem_ce), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      rst = 1'b0;
      do_load(LB, 32'h11, 32'd0, 5'd5, 32'hFFFF_FFF4);
      do_load(LBU, 32'h11, 32'd0, 5'd6, 32'h0000_00F4);
      do_short(SH, 32'h22, 32'h0000_ABCD, 1'b1, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'd0, 1'b0);
      do_short(SB, 32'h20, 32'h0000_005A, 1'b1, 4'b1000, 32'h5A5A_5A5A, 1'b0, 32'd0, 1'b0);
      do_load(LW, 32'h20, 32'd0, 5'd1, 32'h5A00_ABCD);
      do_load(LH, 32'h22, 32'd0, 5'd2, 32'hFFFF_ABCD);
      do_load(LHU, 32'h20, 32'd0, 5'd3, 32'h0000_5A00);
      do_short(SWL, 32'h31, 32'h1122_3344, 1'b1, 4'b0111, 32'h0011_2233, 1'b0, 32'd0, 1'b0);
      do_short(SWR, 32'h35, 32'hAABB_CCDD, 1'b1, 4'b1100, 32'hCCDD_0000, 1'b0, 32'd0, 1'b0);
      do_load(LW, 32'h30, 32'd0, 5'd4, 32'h0011_2233);
      do_load(LW, 32'h34, 32'd0, 5'd4, 32'hCCDD_0000);
      do_short(SW, 32'h24, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
      do_load(LB, 32'h27, 32'd0, 5'd9, 32'hFFFF_FFEF);
      do_load(LBU, 32'h24, 32'd0, 5'd10, 32'h0000_00DE);
      do_load(LWL, 32'h41, 32'hAABB_CCDD, 5'd7, 32'h2233_44DD);
      do_load(LWR, 32'h42, 32'hAABB_CCDD, 5'd8, 32'hAA11_2233);
      do_load(LWL, 32'h40, 32'hAABB_CCDD, 5'd7, 32'h1122_3344);
      do_load(LWR, 32'h43, 32'hAABB_CCDD, 5'd8, 32'h1122_3344);
      do_load(LWR, 32'h40, 32'hAABB_CCDD, 5'd8, 32'hAABB_CC11);
      do_short(LW, 32'h06, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      do_short(SH, 32'h23, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      do_short(LHU, 32'h21, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      do_short(SW, 32'h26, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      do_short(4'd7, 32'h10, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      do_short(4'd15, 32'h10, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive(1'b1, LW, 32'h10, 32'd0, 5'd2);
      #1;
      chk("b2b_ce_n", 32'(bus.mem_ce), 32'd1);
      @(negedge clk);
      #1;
      chk("b2b_ready_n1", 32'(bus.req_ready), 32'd0);
      chk("b2b_ce_n1", 32'(bus.mem_ce), 32'd0);
      @(negedge clk);
      #1;
      chk("b2b_ready_n2", 32'(bus.req_ready), 32'd0);
      chk("b2b_rvalid_n2", 32'(bus.resp_valid), 32'd1);
      chk("b2b_wdata_n2", bus.resp_wdata, 32'h12F4_5678);
      @(negedge clk);
      #1;
      chk("b2b_ready_n3", 32'(bus.req_ready), 32'd1);
      chk("b2b_ce_n3", 32'(bus.mem_ce), 32'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("b2b_idle_n4", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      drive(1'b1, LW, 32'h40, 32'd0, 5'd2);
      #1;
      chk("rstld_ce_n", 32'(bus.mem_ce), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstld_rvalid_n1", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstld_ready_n2", 32'(bus.req_ready), 32'd1);
      chk("rstld_rvalid_n2", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("rstld_rvalid_n3", 32'(bus.resp_valid), 32'd0);
      do_load(LW, 32'h40, 32'd0, 5'd11, 32'h1122_3344);
`ifdef LSU_LLSC_EN
      do_load(LL, 32'h80, 32'd0, 5'd12, 32'h0BAD_F00D);
      do_short(SC, 32'h80, 32'h77, 1'b1, 4'b1111, 32'h77, 1'b1, 32'd1, 1'b0);
      do_load(LW, 32'h80, 32'd0, 5'd1, 32'h77);
      do_load(LL, 32'h80, 32'd0, 5'd12, 32'h77);
      @(negedge clk);
      bus.llbit_clr = 1'b1;
      @(negedge clk);
      bus.llbit_clr = 1'b0;
      do_short(SC, 32'h80, 32'h99, 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b0);
      do_load(LW, 32'h80, 32'd0, 5'd1, 32'h77);
      clr_at_accept = 1'b1;
      do_load(LL, 32'h80, 32'd0, 5'd12, 32'h77);
      clr_at_accept = 1'b0;
      do_short(SC, 32'h80, 32'hAA, 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b0);
      do_short(SC, 32'h80, 32'hBB, 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b0);
`else
      do_short(SC, 32'h80, 32'h77, 1'b1, 4'b1111, 32'h77, 1'b0, 32'd0, 1'b0);
      do_load(LL, 32'h80, 32'd0, 5'd12, 32'h77);
      bus.llbit_clr = 1'b1;
      do_short(SC, 32'h84, 32'h55, 1'b1, 4'b1111, 32'h55, 1'b0, 32'd0, 1'b0);
      bus.llbit_clr = 1'b0;
      do_load(LW, 32'h84, 32'd0, 5'd1, 32'h55);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
